// File: rtl/ayatsuki_dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder and its machine timer.
package ayatsuki_dmem_responder_pkg;

  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_DATA_BUS = 32;

  localparam logic [7:0] MMIO_MTIME_LO    = 8'h00;
  localparam logic [7:0] MMIO_MTIME_HI    = 8'h04;
  localparam logic [7:0] MMIO_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] MMIO_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] MMIO_GPIO_OUT    = 8'h10;
  localparam logic [7:0] MMIO_STATUS      = 8'h14;
  localparam logic [7:0] MMIO_CTRL        = 8'h18;

  localparam int CTRL_IRQ_EN_BIT    = 0;
  localparam int CTRL_RUN_BIT       = 1;
  localparam int STATUS_BUS_ERR_BIT = 0;
  localparam int STATUS_PENDING_BIT = 1;

  // Where an access lands; TGT_NONE covers every address that must raise bus_err.
  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_MMIO
  } target_e;

  // Timer read selector; the two low bits of mmio_reg_e line up with this on purpose.
  typedef enum logic [1:0] {
    TREG_MTIME_LO,
    TREG_MTIME_HI,
    TREG_CMP_LO,
    TREG_CMP_HI
  } treg_e;

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_GPIO     = 3'd4,
    REG_STATUS   = 3'd5,
    REG_CTRL     = 3'd6,
    REG_NONE     = 3'd7
  } mmio_reg_e;

  // Maps a word offset inside the MMIO page to its register.
  function automatic mmio_reg_e mmio_decode(input logic [5:0] word_off);
    case ({word_off, 2'b00})
      MMIO_MTIME_LO:    return REG_MTIME_LO;
      MMIO_MTIME_HI:    return REG_MTIME_HI;
      MMIO_MTIMECMP_LO: return REG_CMP_LO;
      MMIO_MTIMECMP_HI: return REG_CMP_HI;
      MMIO_GPIO_OUT:    return REG_GPIO;
      MMIO_STATUS:      return REG_STATUS;
      MMIO_CTRL:        return REG_CTRL;
      default:          return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ayatsuki_mtimer.sv
// 64-bit machine timer with compare register and registered interrupt output.
module ayatsuki_mtimer
  import ayatsuki_dmem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        irq_en,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  treg_e       rd_sel,
  output logic [31:0] rd_data,
  output logic        pending,
  output logic        irq
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;

  assign pending = (mtime >= mtimecmp);

  // Count, accept compare writes, and register the qualified interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      irq      <= 1'b0;
    end else begin
      if (run) begin
        mtime <= mtime + 64'd1;
      end
      if (wr_en) begin
        if (wr_hi) begin
          mtimecmp[63:32] <= wr_data;
        end else begin
          mtimecmp[31:0] <= wr_data;
        end
      end
      irq <= pending & irq_en;
    end
  end

  // Combinational read of the selected 32-bit half.
  always_comb begin
    rd_data = 32'd0;
    case (rd_sel)
      TREG_MTIME_LO: rd_data = mtime[31:0];
      TREG_MTIME_HI: rd_data = mtime[63:32];
      TREG_CMP_LO:   rd_data = mtimecmp[31:0];
      TREG_CMP_HI:   rd_data = mtimecmp[63:32];
      default:       rd_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/ayatsuki_dmem_responder.sv
// Data-memory responder: word RAM plus MMIO page (timer, GPIO, status, control).
module ayatsuki_dmem_responder
  import ayatsuki_dmem_responder_pkg::*;
#(
  parameter int          RAM_DEPTH = 4096,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_enable_i,
  input  logic                    mem_w_enable_i,
  input  logic                    mem_r_enable_i,
  input  logic [MEM_ADDR_BUS-1:0] mem_w_addr_i,
  input  logic [MEM_ADDR_BUS-1:0] mem_r_addr_i,
  input  logic [MEM_DATA_BUS-1:0] mem_data_i,
  output logic [MEM_DATA_BUS-1:0] mem_data_o,
  output logic [31:0]             gpio_o,
  output logic                    timer_irq_o
);

  localparam int IDX_W = $clog2(RAM_DEPTH);

  // RAM hits need the bits above the index to be zero; MMIO hits need a defined offset.
  function automatic target_e target_of(input logic [31:0] addr);
    if (addr[31:28] == RAM_BASE[31:28]) begin
      return ((addr[27:0] >> (IDX_W + 2)) == 28'd0) ? TGT_RAM : TGT_NONE;
    end else if (addr[31:28] == MMIO_BASE[31:28]) begin
      return (mmio_decode(addr[7:2]) != REG_NONE) ? TGT_MMIO : TGT_NONE;
    end
    return TGT_NONE;
  endfunction

  logic [31:0]      ram [RAM_DEPTH];
  logic [31:0]      gpio_q;
  logic [1:0]       ctrl_q;
  logic             bus_err_q;

  logic             rd_req, wr_req;
  target_e          rd_tgt, wr_tgt;
  mmio_reg_e        rd_reg, wr_reg;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rd_err, wr_err;
  logic             ram_we, gpio_we, ctrl_we, status_we, tmr_we;
  logic             tmr_wr_hi;
  treg_e            tmr_rd_sel;
  logic [31:0]      tmr_rd_data;
  logic             tmr_pending;

  assign rd_req     = mem_enable_i & mem_r_enable_i;
  assign wr_req     = mem_enable_i & mem_w_enable_i;
  assign rd_tgt     = target_of(mem_r_addr_i);
  assign wr_tgt     = target_of(mem_w_addr_i);
  assign rd_reg     = mmio_decode(mem_r_addr_i[7:2]);
  assign wr_reg     = mmio_decode(mem_w_addr_i[7:2]);
  assign rd_idx     = mem_r_addr_i[IDX_W+1:2];
  assign wr_idx     = mem_w_addr_i[IDX_W+1:2];
  assign tmr_rd_sel = treg_e'(rd_reg[1:0]);
  assign tmr_wr_hi  = (wr_reg == REG_CMP_HI);
  assign gpio_o     = gpio_q;

  ayatsuki_mtimer u_mtimer (
    .clk     (clk),
    .rst     (rst),
    .run     (ctrl_q[CTRL_RUN_BIT]),
    .irq_en  (ctrl_q[CTRL_IRQ_EN_BIT]),
    .wr_en   (tmr_we),
    .wr_hi   (tmr_wr_hi),
    .wr_data (mem_data_i),
    .rd_sel  (tmr_rd_sel),
    .rd_data (tmr_rd_data),
    .pending (tmr_pending),
    .irq     (timer_irq_o)
  );

  // Same-cycle read path; any read of a hole returns zero and flags a bus error.
  always_comb begin
    mem_data_o = '0;
    rd_err     = 1'b0;
    if (rd_req) begin
      case (rd_tgt)
        TGT_RAM:  mem_data_o = ram[rd_idx];
        TGT_MMIO: begin
          case (rd_reg)
            REG_MTIME_LO, REG_MTIME_HI,
            REG_CMP_LO, REG_CMP_HI: mem_data_o = tmr_rd_data;
            REG_GPIO:   mem_data_o = gpio_q;
            REG_STATUS: mem_data_o = {30'd0, tmr_pending, bus_err_q};
            REG_CTRL:   mem_data_o = {30'd0, ctrl_q};
            default:    mem_data_o = '0;
          endcase
        end
        default:  rd_err = 1'b1;
      endcase
    end
  end

  // Write decode into per-target strobes; writes to MTIME are silently ignored.
  always_comb begin
    ram_we    = 1'b0;
    gpio_we   = 1'b0;
    ctrl_we   = 1'b0;
    status_we = 1'b0;
    tmr_we    = 1'b0;
    wr_err    = 1'b0;
    if (wr_req) begin
      case (wr_tgt)
        TGT_RAM:  ram_we = 1'b1;
        TGT_MMIO: begin
          case (wr_reg)
            REG_CMP_LO, REG_CMP_HI: tmr_we = 1'b1;
            REG_GPIO:   gpio_we   = 1'b1;
            REG_STATUS: status_we = 1'b1;
            REG_CTRL:   ctrl_we   = 1'b1;
            default:    ;
          endcase
        end
        default:  wr_err = 1'b1;
      endcase
    end
  end

  // RAM array is not reset, but a write coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      ram[wr_idx] <= mem_data_i;
    end
  end

  // GPIO, CTRL and the sticky bus error; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q    <= 32'd0;
      ctrl_q    <= 2'b10;
      bus_err_q <= 1'b0;
    end else begin
      if (gpio_we) begin
        gpio_q <= mem_data_i;
      end
      if (ctrl_we) begin
        ctrl_q <= mem_data_i[1:0];
      end
      if (rd_err || wr_err) begin
        bus_err_q <= 1'b1;
      end else if (status_we && mem_data_i[STATUS_BUS_ERR_BIT]) begin
        bus_err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ayatsuki_dmem_responder.sv
// Directed and randomized checks of the responder against a behavioural model.
module tb_ayatsuki_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enable_i, mem_w_enable_i, mem_r_enable_i;
  logic [31:0] mem_w_addr_i, mem_r_addr_i, mem_data_i;
  logic [31:0] mem_data_o, gpio_o;
  logic        timer_irq_o;

  int checks = 0;
  int errors = 0;

  // Reference state, kept at register-map level.
  logic [31:0] m_ram [4096];
  bit          m_known [4096];
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_gpio;
  logic [1:0]  m_ctrl;
  bit          m_bus_err, m_irq;

  logic [31:0] obs_rd;
  logic        obs_irq;

  always #5 clk = ~clk;

  ayatsuki_dmem_responder dut (
    .clk            (clk),
    .rst            (rst),
    .mem_enable_i   (mem_enable_i),
    .mem_w_enable_i (mem_w_enable_i),
    .mem_r_enable_i (mem_r_enable_i),
    .mem_w_addr_i   (mem_w_addr_i),
    .mem_r_addr_i   (mem_r_addr_i),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o),
    .gpio_o         (gpio_o),
    .timer_irq_o    (timer_irq_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // 0 = hole (bus error), 1 = RAM word, 2 = defined MMIO register.
  function automatic int classify(input logic [31:0] a);
    logic [7:0] off;
    off = a[7:0] & 8'hFC;
    if (a[31:28] == 4'h0) return (a[27:0] < 28'h000_4000) ? 1 : 0;
    if (a[31:28] == 4'h1) begin
      if (off <= 8'h18) return 2;
      return 0;
    end
    return 0;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a, output bit known);
    logic [7:0] off;
    known = 1'b1;
    off = a[7:0] & 8'hFC;
    case (classify(a))
      1: begin
        known = m_known[a[13:2]];
        return m_ram[a[13:2]];
      end
      2: begin
        case (off)
          8'h00:   return m_mtime[31:0];
          8'h04:   return m_mtime[63:32];
          8'h08:   return m_cmp[31:0];
          8'h0C:   return m_cmp[63:32];
          8'h10:   return m_gpio;
          8'h14:   return {30'd0, (m_mtime >= m_cmp), m_bus_err};
          default: return {30'd0, m_ctrl};
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic applyStimulus(input bit r, input bit en, input bit we, input bit re,
                               input logic [31:0] wa, input logic [31:0] ra, input logic [31:0] wd);
    logic [31:0] exp;
    bit          known;
    bit          pend, rd_err, wr_err;
    logic [7:0]  woff;
    rst = r; mem_enable_i = en; mem_w_enable_i = we; mem_r_enable_i = re;
    mem_w_addr_i = wa; mem_r_addr_i = ra; mem_data_i = wd;
    #1;
    obs_rd  = mem_data_o;
    obs_irq = timer_irq_o;
    known = 1'b1;
    exp = 32'd0;
    if (en && re) exp = modelRead(ra, known);
    if (!r) begin
      if (known) checkOutput("rdata", mem_data_o, exp);
      checkOutput("gpio", gpio_o, m_gpio);
      checkOutput("irq", {31'd0, timer_irq_o}, {31'd0, m_irq});
    end
    @(posedge clk);
    if (r) begin
      m_mtime = 64'd0; m_cmp = '1; m_gpio = 32'd0; m_ctrl = 2'b10;
      m_bus_err = 1'b0; m_irq = 1'b0;
    end else begin
      pend   = (m_mtime >= m_cmp);
      m_irq  = pend & m_ctrl[0];
      if (m_ctrl[1]) m_mtime = m_mtime + 64'd1;
      rd_err = en && re && (classify(ra) == 0);
      wr_err = en && we && (classify(wa) == 0);
      woff   = wa[7:0] & 8'hFC;
      if (en && we && classify(wa) == 1) begin
        m_ram[wa[13:2]] = wd;
        m_known[wa[13:2]] = 1'b1;
      end
      if (rd_err || wr_err) m_bus_err = 1'b1;
      else if (en && we && classify(wa) == 2 && woff == 8'h14 && wd[0]) m_bus_err = 1'b0;
      if (en && we && classify(wa) == 2) begin
        case (woff)
          8'h08:   m_cmp[31:0]  = wd;
          8'h0C:   m_cmp[63:32] = wd;
          8'h10:   m_gpio = wd;
          8'h18:   m_ctrl = wd[1:0];
          default: ;
        endcase
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 5))
      0, 1:    return ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      2:       return 32'h0000_4000 | ($urandom_range(0, 255) << 2);
      3, 4:    return 32'h1000_0000 | ($urandom_range(0, 8) << 2);
      default: return 32'h2000_0000 | $urandom_range(0, 1023);
    endcase
  endfunction

  // Hard stop in case the bench ever stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; mem_enable_i = 0; mem_w_enable_i = 0; mem_r_enable_i = 0;
    mem_w_addr_i = 0; mem_r_addr_i = 0; mem_data_i = 0;
    for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;
    m_mtime = 0; m_cmp = '1; m_gpio = 0; m_ctrl = 2'b10; m_bus_err = 0; m_irq = 0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 32'h1000_0018, 0);
    checkOutput("rst_ctrl", obs_rd, 32'h2);
    applyStimulus(0, 1, 0, 1, 0, 32'h1000_000C, 0);
    checkOutput("rst_cmp_hi", obs_rd, 32'hFFFF_FFFF);

    // Test 1: write then read back; same-cycle read sees old value
    applyStimulus(0, 1, 1, 0, 32'h10, 0, 32'h1111_2222);
    applyStimulus(0, 1, 1, 1, 32'h10, 32'h10, 32'hDEAD_BEEF);
    checkOutput("t1_same_cycle_old", obs_rd, 32'h1111_2222);
    applyStimulus(0, 1, 0, 1, 0, 32'h10, 0);
    checkOutput("t1_readback", obs_rd, 32'hDEAD_BEEF);

    // Test 2: out-of-range RAM write, bus_err set and cleared
    applyStimulus(0, 1, 1, 0, 32'h0, 0, 32'hCAFE_0000);
    applyStimulus(0, 1, 1, 0, 32'h4000, 0, 32'h5555_AAAA);
    applyStimulus(0, 1, 0, 1, 0, 32'h0, 0);
    checkOutput("t2_ram_unchanged", obs_rd, 32'hCAFE_0000);
    applyStimulus(0, 1, 0, 1, 0, 32'h1000_0014, 0);
    checkOutput("t2_bus_err_set", obs_rd & 32'h1, 32'h1);
    applyStimulus(0, 1, 1, 0, 32'h1000_0014, 0, 32'h1);
    applyStimulus(0, 1, 0, 1, 0, 32'h1000_0014, 0);
    checkOutput("t2_bus_err_clr", obs_rd & 32'h1, 32'h0);

    // Test 3: compare match raises irq one cycle later; raising cmp drops it
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 32'h1000_000C, 0, 32'd0);
    applyStimulus(0, 1, 1, 0, 32'h1000_0008, 0, 32'd20);
    applyStimulus(0, 1, 1, 0, 32'h1000_0018, 0, 32'd3);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus(0, 1, 0, 1, 0, 32'h1000_0000, 0);
      if (obs_rd == 32'd20) found = 1'b1;
    end
    if (!found) checkOutput("t3_timeout", 32'd0, 32'd1);
    checkOutput("t3_irq_at_20", {31'd0, obs_irq}, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_irq_rise", {31'd0, obs_irq}, 32'd1);
    applyStimulus(0, 1, 1, 0, 32'h1000_0008, 0, 32'hFFFF_FFFF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_irq_fall", {31'd0, obs_irq}, 32'd0);

    // Test 4: wrap of mtime with compare at all-ones
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 32'h1000_0018, 0, 32'd3);
    dut.u_mtimer.mtime = 64'hFFFF_FFFF_FFFF_FFFE;
    m_mtime = 64'hFFFF_FFFF_FFFF_FFFE;
    applyStimulus(0, 1, 0, 1, 0, 32'h1000_0000, 0);
    checkOutput("t4_fe", obs_rd, 32'hFFFF_FFFE);
    checkOutput("t4_irq_fe", {31'd0, obs_irq}, 32'd0);
    applyStimulus(0, 1, 0, 1, 0, 32'h1000_0000, 0);
    checkOutput("t4_ff", obs_rd, 32'hFFFF_FFFF);
    checkOutput("t4_irq_ff", {31'd0, obs_irq}, 32'd0);
    applyStimulus(0, 1, 0, 1, 0, 32'h1000_0004, 0);
    checkOutput("t4_wrap_hi", obs_rd, 32'h0);
    checkOutput("t4_irq_after_ff", {31'd0, obs_irq}, 32'd1);

    // Test 5: GPIO write needs the global enable
    applyStimulus(0, 0, 1, 0, 32'h1000_0010, 0, 32'h0000_00A5);
    checkOutput("t5_gpio_gated", gpio_o, 32'h0);
    applyStimulus(0, 1, 1, 0, 32'h1000_0010, 0, 32'h0000_00A5);
    checkOutput("t5_gpio_set", gpio_o, 32'h0000_00A5);

    // Test 6: reset during a RAM write discards it
    applyStimulus(0, 1, 1, 0, 32'h8, 0, 32'h1234_5678);
    applyStimulus(1, 1, 1, 0, 32'h8, 0, 32'hFFFF_0000);
    checkOutput("t6_gpio_rst", gpio_o, 32'h0);
    checkOutput("t6_irq_rst", {31'd0, timer_irq_o}, 32'd0);
    applyStimulus(0, 1, 0, 1, 0, 32'h1000_0000, 0);
    checkOutput("t6_mtime_rst", obs_rd, 32'h0);
    applyStimulus(0, 1, 0, 1, 0, 32'h8, 0);
    checkOutput("t6_ram_kept", obs_rd, 32'h1234_5678);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                    1'($urandom), 1'($urandom), randAddr(), randAddr(), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
